// File: rtl/shift_frame_tx.sv
// rtl/shift_frame_tx.sv - 41-bit serial frame transmitter with double-edge serial clock
//
// Sends {tx_addr, tx_data, 1'b1} MSB-first on sda, framed by sen. The far-end
// shifter samples sda on both sck edges, so sck toggles once per bit, in the
// middle of the bit. After the frame the line idles with sen low for the gap.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tx_valid  in   request to send one frame
//   tx_ready  out  high in IDLE; accept = tx_valid & tx_ready on a rising edge
//   tx_addr   in   8-bit address field (sent first)
//   tx_data   in   32-bit data field
//   sck       out  serial clock, one transition per bit
//   sen       out  serial enable, high only while frame bits are on the line
//   sda       out  serial data
//   busy      out  high from acceptance until the end of the gap
//   done      out  one-cycle pulse on the last gap cycle

module shift_frame_tx #(
    parameter int unsigned HALF_CYC = 1,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_addr,
    input  logic [31:0] tx_data,
    output logic        sck,
    output logic        sen,
    output logic        sda,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HALF_RELOAD = 8'(HALF_CYC - 1);
    localparam logic [7:0] GAP_RELOAD  = 8'(GAP_CYC);
    localparam logic [5:0] LAST_BIT    = 6'd40;

    state_t      state_q, state_d;
    logic [40:0] frame_q, frame_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  half_cnt_q, half_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        phase_q, phase_d;
    logic        sck_q, sck_d;
    logic        sen_q, sen_d;
    logic        sda_q, sda_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            half_cnt_q <= '0;
            gap_cnt_q  <= '0;
            phase_q    <= 1'b0;
            sck_q      <= 1'b0;
            sen_q      <= 1'b0;
            sda_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            half_cnt_q <= half_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            phase_q    <= phase_d;
            sck_q      <= sck_d;
            sen_q      <= sen_d;
            sda_q      <= sda_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        half_cnt_d = half_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        phase_d    = phase_q;
        sck_d      = sck_q;
        sen_d      = sen_q;
        sda_d      = sda_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    // frame_q[40] is always the bit currently on the line
                    state_d    = ST_SHIFT;
                    frame_d    = {tx_addr, tx_data, 1'b1};
                    bit_cnt_d  = '0;
                    half_cnt_d = HALF_RELOAD;
                    phase_d    = 1'b0;
                    sck_d      = 1'b0;
                    sen_d      = 1'b1;
                    sda_d      = tx_addr[7];
                end
            end

            ST_SHIFT: begin
                if (half_cnt_q != 8'd0) begin
                    half_cnt_d = half_cnt_q - 8'd1;
                end else if (!phase_q) begin
                    // middle of the bit: the single sck transition
                    sck_d      = ~sck_q;
                    phase_d    = 1'b1;
                    half_cnt_d = HALF_RELOAD;
                end else begin
                    // end of the bit
                    phase_d    = 1'b0;
                    half_cnt_d = HALF_RELOAD;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_GAP;
                        sen_d     = 1'b0;
                        sda_d     = 1'b0;
                        gap_cnt_d = GAP_RELOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        frame_d   = {frame_q[39:0], 1'b0};
                        sda_d     = frame_q[39];
                    end
                end
            end

            ST_GAP: begin
                // sck ends the frame high after 41 transitions; return it to 0
                // while sen is low so the next frame starts with sck low.
                // The first gap cycle carries that return, then GAP_CYC more.
                sck_d = 1'b0;
                if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_GAP) && (gap_cnt_q == 8'd0);
    assign sck      = sck_q;
    assign sen      = sen_q;
    assign sda      = sda_q;

endmodule

// File: tb/tb_shift_frame_tx.sv
// tb/tb_shift_frame_tx.sv - bench for shift_frame_tx with a double-edge receive shifter model

module tb_shift_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n_r;
    logic [1:0]  valid_r;
    logic [7:0]  addr_r [2];
    logic [31:0] data_r [2];
    logic [1:0]  ready_w, sck_w, sen_w, sda_w, busy_w, done_w;

    int hc [2] = '{1, 3};
    int gc [2] = '{2, 4};

    int errors = 0;
    int checks = 0;

    shift_frame_tx #(.HALF_CYC(1), .GAP_CYC(2)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n_r[0]),
        .tx_valid (valid_r[0]),
        .tx_ready (ready_w[0]),
        .tx_addr  (addr_r[0]),
        .tx_data  (data_r[0]),
        .sck      (sck_w[0]),
        .sen      (sen_w[0]),
        .sda      (sda_w[0]),
        .busy     (busy_w[0]),
        .done     (done_w[0])
    );

    shift_frame_tx #(.HALF_CYC(3), .GAP_CYC(4)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n_r[1]),
        .tx_valid (valid_r[1]),
        .tx_ready (ready_w[1]),
        .tx_addr  (addr_r[1]),
        .tx_data  (data_r[1]),
        .sck      (sck_w[1]),
        .sen      (sen_w[1]),
        .sda      (sda_w[1]),
        .busy     (busy_w[1]),
        .done     (done_w[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line bit i of a frame: address MSB-first, data MSB-first, marker.
    function automatic logic exp_bit(input logic [7:0] a, input logic [31:0] d, input int i);
        if (i < 8) return a[7-i];
        if (i < 40) return d[39-i];
        return 1'b1;
    endfunction

    // Called at a negedge with the DUT idle. rst_bit >= 0 aborts the frame
    // with reset at the start of that bit.
    task automatic run_frame(input int u, input logic [7:0] a, input logic [31:0] d,
                             input bit hold, input bit inject, input int rst_bit);
        int h, g, ftime, ntr, ndone, done_c, mism, senlow, lim, tcount, extra;
        logic [40:0] rx;
        logic prev_sck, o_sck, o_sen, o_sda, e_sck, e_sen, e_sda;
        h = hc[u];
        g = gc[u];
        ftime = -1; ntr = 0; ndone = 0; done_c = -1; mism = 0; senlow = 0;
        rx = '0;
        prev_sck = 1'b0;
        lim = 82 * h + g + 40;

        valid_r[u] = 1'b1;
        addr_r[u]  = a;
        data_r[u]  = d;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            valid_r[u] = 1'b0;
            addr_r[u]  = 8'($urandom);
            data_r[u]  = $urandom;
        end

        for (int c = 0; c < lim; c++) begin
            if (c > 0) @(negedge clk);
            o_sck = sck_w[u];
            o_sen = sen_w[u];
            o_sda = sda_w[u];

            if (rst_bit >= 0 && c == rst_bit * 2 * h) begin
                chk("pre_reset_lines", 64'(mism), 64'd0);
                rst_n_r[u] = 1'b0;
                #1;
                chk("reset_mid_lines", {61'd0, sck_w[u], sen_w[u], sda_w[u]}, 64'd0);
                chk("reset_mid_ready_busy", {62'd0, ready_w[u], busy_w[u]}, 64'd2);
                @(posedge clk);
                #1;
                chk("reset_hold_sck", {63'd0, sck_w[u]}, 64'd0);
                @(negedge clk);
                rst_n_r[u] = 1'b1;
                #1;
                chk("reset_release_ready", {63'd0, ready_w[u]}, 64'd1);
                return;
            end

            if (c < 82 * h) begin
                e_sen = 1'b1;
                e_sda = exp_bit(a, d, c / (2 * h));
            end else begin
                e_sen = 1'b0;
                e_sda = 1'b0;
            end
            if (c <= 82 * h) begin
                tcount = (c >= h) ? (c - h) / (2 * h) + 1 : 0;
                e_sck  = (tcount % 2) == 1;
            end else begin
                e_sck = 1'b0;
            end
            if (o_sck !== e_sck || o_sen !== e_sen || o_sda !== e_sda) mism++;

            if (o_sen && o_sck !== prev_sck) begin
                rx = {rx[39:0], o_sda};
                ntr++;
            end
            prev_sck = o_sck;
            if (c >= 82 * h && !o_sen) senlow++;
            if (done_w[u]) begin
                ndone++;
                done_c = c;
            end

            if (inject && c == 10) begin
                valid_r[u] = 1'b1;
                addr_r[u]  = ~a;
                data_r[u]  = ~d;
            end
            if (inject && c == 11) valid_r[u] = 1'b0;

            if (ready_w[u]) begin
                ftime = c;
                break;
            end
        end

        chk("frame_time", 64'(ftime), 64'(82 * h + g + 1));
        chk("line_sequence", 64'(mism), 64'd0);
        chk("sck_edges_sen_high", 64'(ntr), 64'd41);
        chk("rx_addr", 64'(rx[40:33]), 64'(a));
        chk("rx_data", 64'(rx[32:1]), 64'(d));
        chk("rx_marker", 64'(rx[0]), 64'd1);
        chk("done_count", 64'(ndone), 64'd1);
        chk("done_position", 64'(done_c), 64'(82 * h + g));
        if (hold) chk("gap_sen_low", 64'(senlow), 64'(g + 2));

        if (inject) begin
            extra = 0;
            repeat (100) begin
                @(negedge clk);
                if (sen_w[u] !== 1'b0 || ready_w[u] !== 1'b1 || sck_w[u] !== 1'b0) extra++;
            end
            chk("no_second_frame", 64'(extra), 64'd0);
        end
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;

        rst_n_r = 2'b00;
        valid_r = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_r[i] = '0;
            data_r[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_outputs",
                {58'd0, ready_w[i], busy_w[i], done_w[i], sck_w[i], sen_w[i], sda_w[i]},
                64'b100000);
        end
        rst_n_r = 2'b11;

        // reference frame, fast config
        run_frame(0, 8'hA5, 32'hDEADBEEF, 1'b0, 1'b0, -1);
        // loopback frame
        run_frame(0, 8'h3C, 32'h12345678, 1'b0, 1'b0, -1);
        // slow config: 6-cycle bits, 251-cycle frame
        run_frame(1, 8'($urandom), $urandom, 1'b0, 1'b0, -1);

        // request pulsed mid-frame is ignored
        run_frame(0, 8'($urandom), $urandom, 1'b0, 1'b1, -1);

        // valid held high: three identical back-to-back frames
        ra = 8'($urandom);
        rd = $urandom;
        run_frame(0, ra, rd, 1'b1, 1'b0, -1);
        run_frame(0, ra, rd, 1'b1, 1'b0, -1);
        run_frame(0, ra, rd, 1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);

        // reset at bit 20, then a complete frame
        run_frame(0, 8'($urandom), $urandom, 1'b0, 1'b0, 20);
        run_frame(0, 8'($urandom), $urandom, 1'b0, 1'b0, -1);

        // slow config: held valid, then reset mid-frame and recovery
        ra = 8'($urandom);
        rd = $urandom;
        run_frame(1, ra, rd, 1'b1, 1'b0, -1);
        run_frame(1, ra, rd, 1'b0, 1'b0, -1);
        run_frame(1, 8'($urandom), $urandom, 1'b0, 1'b0, 20);
        run_frame(1, 8'($urandom), $urandom, 1'b0, 1'b1, -1);

        for (int k = 0; k < 4; k++) begin
            run_frame(0, 8'($urandom), $urandom, 1'b0, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
